// File: rtl/pipe_ctrl_pkg.sv
// Shared encodings and shadow-slot types for the EX-stage forwarding/hazard scheduler.
// The STALL_CNT_EN build option is consumed by fwd_hazard_ctrl, not here.
package pipe_ctrl_pkg;

   localparam int SLOT_AW = 5;

   localparam logic [1:0] FWD_RF    = 2'b00;
   localparam logic [1:0] FWD_EXMEM = 2'b01;
   localparam logic [1:0] FWD_MEMWB = 2'b10;
   localparam logic [1:0] FWD_IMM   = 2'b11;

   localparam logic [SLOT_AW-1:0] REG_ZERO = '0;

   typedef struct packed {
      logic [SLOT_AW-1:0] dst;
      logic               wr;
   } wb_slot_t;

   // The EX slot additionally remembers whether its producer is a load.
   typedef struct packed {
      wb_slot_t wb;
      logic     ld;
   } ex_slot_t;

endpackage

// File: rtl/fwd_src_cmp.sv
// Per-source hit detection and select priority against the EX and MEM shadow slots.
// The youngest in-flight producer wins; r0 never forwards.
module fwd_src_cmp
   import pipe_ctrl_pkg::*;
(
   input  logic [SLOT_AW-1:0] i_idx,
   input  logic               i_used,
   input  wb_slot_t           i_ex,
   input  wb_slot_t           i_mem,
   output logic               o_hit_ex,
   output logic [1:0]         o_next_sel
);

   logic w_live;
   logic w_hit_mem;

   assign w_live    = i_used && (i_idx != REG_ZERO);
   assign o_hit_ex  = w_live && i_ex.wr  && (i_ex.dst  == i_idx);
   assign w_hit_mem = w_live && i_mem.wr && (i_mem.dst == i_idx);

   always_comb begin
      o_next_sel = FWD_RF;
      if (o_hit_ex) begin
         o_next_sel = FWD_EXMEM;
      end else if (w_hit_mem) begin
         o_next_sel = FWD_MEMWB;
      end
   end

endmodule

// File: rtl/fwd_hazard_ctrl.sv
// Forwarding select scheduler and load-use stall generator for the EX operand muxes.
// Define STALL_CNT_EN to build the saturating stall-cycle counter; otherwise stall_cnt_o is 0.
module fwd_hazard_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter int REG_AW = SLOT_AW,
   parameter int CNT_W  = 32
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              id_valid_i,
   input  logic [REG_AW-1:0] id_rs_i,
   input  logic [REG_AW-1:0] id_rt_i,
   input  logic              id_rs_used_i,
   input  logic              id_rt_used_i,
   input  logic              id_alu_src_i,
   input  logic [REG_AW-1:0] id_dst_i,
   input  logic              id_reg_write_i,
   input  logic              id_mem_read_i,
   input  logic              flush_i,
   output logic              stall_o,
   output logic [1:0]        fwd_a_sel_o,
   output logic [1:0]        fwd_b_sel_o,
   output logic [CNT_W-1:0]  stall_cnt_o
);

   ex_slot_t   r_ex;
   wb_slot_t   r_mem;
   logic [1:0] r_fwd_a;
   logic [1:0] r_fwd_b;

   logic       w_hit_ex_a;
   logic       w_hit_ex_b;
   logic [1:0] w_sel_a;
   logic [1:0] w_sel_b;
   logic       w_bubble;

   fwd_src_cmp u_cmp_a (
      .i_idx      (id_rs_i),
      .i_used     (id_rs_used_i),
      .i_ex       (r_ex.wb),
      .i_mem      (r_mem),
      .o_hit_ex   (w_hit_ex_a),
      .o_next_sel (w_sel_a)
   );

   fwd_src_cmp u_cmp_b (
      .i_idx      (id_rt_i),
      .i_used     (id_rt_used_i),
      .i_ex       (r_ex.wb),
      .i_mem      (r_mem),
      .o_hit_ex   (w_hit_ex_b),
      .o_next_sel (w_sel_b)
   );

   // An immediate operand B never reads rt, so it cannot cause a load-use stall.
   assign stall_o  = !rst_i && id_valid_i && !flush_i && r_ex.ld &&
                     (w_hit_ex_a || (w_hit_ex_b && !id_alu_src_i));
   assign w_bubble = flush_i || stall_o || !id_valid_i;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_ex    <= '0;
         r_mem   <= '0;
         r_fwd_a <= FWD_RF;
         r_fwd_b <= FWD_RF;
      end else begin
         r_mem <= r_ex.wb;
         if (w_bubble) begin
            r_ex    <= '0;
            r_fwd_a <= FWD_RF;
            r_fwd_b <= FWD_RF;
         end else begin
            r_ex.wb.dst <= id_dst_i;
            r_ex.wb.wr  <= id_reg_write_i;
            r_ex.ld     <= id_mem_read_i;
            r_fwd_a     <= w_sel_a;
            r_fwd_b     <= id_alu_src_i ? FWD_IMM : w_sel_b;
         end
      end
   end

   assign fwd_a_sel_o = r_fwd_a;
   assign fwd_b_sel_o = r_fwd_b;

`ifdef STALL_CNT_EN
   logic [CNT_W-1:0] r_stall_cnt;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_stall_cnt <= '0;
      end else if (stall_o && (r_stall_cnt != '1)) begin
         r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      end
   end

   assign stall_cnt_o = r_stall_cnt;
`else
   assign stall_cnt_o = '0;
`endif

endmodule
